// File: rtl/serial_arbiter.sv
// Round-robin arbiter that forwards byte bursts from NUM_REQ requesters to a single
// serializer, holding each grant until the serializer shifts out the final bit.
module serial_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mask,
    output logic                           ser_valid,
    output logic [DATAWIDTH-1:0]           ser_data,
    input  logic                           ser_ready,
    input  logic                           ser_last,
    input  logic                           ser_ack,
    output logic [NUM_REQ-1:0]             grant,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] elig_s;
    logic               sel_found_s;
    logic [IDW-1:0]     sel_id_s;
    logic [IDW:0]       idx_s;
    logic               hs_s;

    assign elig_s = req_valid & req_mask;
    assign hs_s   = (state_q == ST_FWD) && req_valid[grant_id_q] && ser_ready;

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        sel_found_s = 1'b0;
        sel_id_s    = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(NUM_REQ)) begin
                idx_s = idx_s - (IDW+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!sel_found_s && elig_s[idx_s[IDW-1:0]]) begin
                sel_found_s = 1'b1;
                sel_id_s    = idx_s[IDW-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state logic for the IDLE / FWD / DRAIN sequencer
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_d    = ST_FWD;
                    grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id_s;
                    grant_id_d = sel_id_s;
                    beat_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (hs_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (req_last[grant_id_q] || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FWD;
                    end
                end else begin
                    state_d = ST_FWD;
                end
            end
            ST_DRAIN: begin
                // Grant is held until the serializer finishes shifting the last byte
                if (ser_last && ser_ack) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    if (grant_id_q == IDW'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_id_q + IDW'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                beat_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    // Zero-latency byte path from the granted requester while forwarding
    always_comb begin
        ser_valid = 1'b0;
        ser_data  = '0;
        req_ready = '0;
        if (state_q == ST_FWD) begin
            ser_valid            = req_valid[grant_id_q];
            ser_data             = req_data[grant_id_q*DATAWIDTH +: DATAWIDTH];
            req_ready[grant_id_q] = ser_ready;
        end else begin
            ser_valid = 1'b0;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_serial_arbiter.sv
// Scoreboard bench for serial_arbiter (NUM_REQ=4, DATAWIDTH=8, MAX_BURST=4):
// stimulus queues expected bytes, a monitor checks every serializer handshake.
module tb_serial_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  req_mask;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic        ser_ready;
    logic        ser_last;
    logic        ser_ack;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;

    serial_arbiter #(.DATAWIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .req_mask(req_mask),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
        .ser_last(ser_last), .ser_ack(ser_ack),
        .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int id; } exp_t;
    exp_t        exp_q[$];
    logic [8:0]  rq[4][$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          hs_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        exp_t e;
        rq[r].push_back({last, d});
        e.data = d;
        e.id   = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int n, input string name);
        int i;
        i = 0;
        while (hs_cnt < n && i < 200) begin
            cyc();
            i++;
        end
        check(name, hs_cnt, n);
    endtask

    task automatic drain();
        ser_last = 1'b1;
        ser_ack  = 1'b1;
        cyc();
        ser_last = 1'b0;
        ser_ack  = 1'b0;
    endtask

    // Requester models: present queue heads, pop on a handshake seen at the previous negedge
    initial begin
        logic [3:0] hs_v;
        logic [8:0] ent;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        req_last  = 4'b0000;
        forever begin
            @(negedge clk);
            hs_v = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (hs_v[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    ent = rq[i][0];
                    req_valid[i]       = 1'b1;
                    req_last[i]        = ent[8];
                    req_data[i*8 +: 8] = ent[7:0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                end
            end
        end
    end

    // Monitor: every serializer handshake must match the next expected byte and owner
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ser_valid === 1'b1 && ser_ready === 1'b1) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, ser_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("ser_data", {24'h0, ser_data}, {24'h0, e.data});
                    check("grant_id_at_hs", {30'h0, grant_id}, e.id);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_mask = 4'b1111; ser_ready = 1'b0; ser_last = 1'b0; ser_ack = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_grant", {28'h0, grant}, 32'h0);
        check("rst_grant_id", {30'h0, grant_id}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ser_valid", {31'h0, ser_valid}, 32'h0);
        check("rst_req_ready", {28'h0, req_ready}, 32'h0);

        // Two contenders from rr_ptr=0: requester 1 first, then 3
        cyc();
        ser_ready = 1'b1;
        push(1, 8'h11, 1'b1);
        push(3, 8'h33, 1'b1);
        cyc();
        check("rr_first_grant", {28'h0, grant}, 32'h2);
        check("rr_first_id", {30'h0, grant_id}, 32'h1);
        wait_hs(1, "rr_hs1");
        check("drain_grant_held", {28'h0, grant}, 32'h2);
        @(negedge clk);
        check("drain_ser_valid", {31'h0, ser_valid}, 32'h0);
        check("drain_req_ready", {28'h0, req_ready}, 32'h0);
        cyc();
        ser_last = 1'b1;
        cyc();
        ser_last = 1'b0;
        check("last_no_ack_ignored", {31'h0, busy}, 32'h1);
        drain();
        check("drain_done_grant", {28'h0, grant}, 32'h0);
        check("drain_done_busy", {31'h0, busy}, 32'h0);
        cyc();
        check("rr_second_grant", {28'h0, grant}, 32'h8);
        check("rr_second_id", {30'h0, grant_id}, 32'h3);
        wait_hs(2, "rr_hs2");
        drain();

        // Requester 0 three-byte frame; drain held until ser_last & ser_ack
        push(0, 8'hA5, 1'b0);
        push(0, 8'h3C, 1'b0);
        push(0, 8'hFF, 1'b1);
        cyc();
        check("frame_grant", {28'h0, grant}, 32'h1);
        wait_hs(5, "frame_hs");
        repeat (3) cyc();
        check("frame_drain_busy", {31'h0, busy}, 32'h1);
        drain();
        check("frame_busy_fall", {31'h0, busy}, 32'h0);
        check("frame_exact_hs", hs_cnt, 32'd5);

        // Six unterminated bytes from requester 2 with MAX_BURST=4
        for (int b = 0; b < 6; b++) push(2, 8'h20 + 8'(b), 1'b0);
        cyc();
        check("burst_grant", {28'h0, grant}, 32'h4);
        wait_hs(9, "burst_4_bytes");
        check("burst_drain_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("burst_drain_no_valid", {31'h0, ser_valid}, 32'h0);
        drain();
        check("burst_idle_gap", {28'h0, grant}, 32'h0);
        cyc();
        check("burst_regrant", {28'h0, grant}, 32'h4);
        wait_hs(11, "burst_2nd_grant");
        cyc();
        check("stall_busy", {31'h0, busy}, 32'h1);
        check("stall_grant", {28'h0, grant}, 32'h4);
        @(negedge clk);
        check("stall_no_valid", {31'h0, ser_valid}, 32'h0);

        // Reset mid-burst; search restarts at index 0 (would pick 3 from rr_ptr=3)
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_grant", {28'h0, grant}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_grant_id", {30'h0, grant_id}, 32'h0);
        @(negedge clk);
        check("midrst_req_ready", {28'h0, req_ready}, 32'h0);
        cyc();
        push(1, 8'h41, 1'b1);
        push(3, 8'h43, 1'b1);
        cyc();
        check("postrst_grant", {28'h0, grant}, 32'h2);
        wait_hs(12, "postrst_hs1");
        drain();
        cyc();
        check("postrst_grant2", {28'h0, grant}, 32'h8);
        wait_hs(13, "postrst_hs2");
        drain();

        // ser_ready toggling during FWD
        ser_ready = 1'b0;
        push(0, 8'hB0, 1'b0);
        push(0, 8'hB1, 1'b0);
        push(0, 8'hB2, 1'b1);
        cyc();
        @(negedge clk);
        check("tog_valid", {31'h0, ser_valid}, 32'h1);
        check("tog_ready0", {28'h0, req_ready}, 32'h0);
        cyc();
        ser_ready = 1'b1;
        @(negedge clk);
        check("tog_ready1", {28'h0, req_ready}, 32'h1);
        cyc();
        ser_ready = 1'b0;
        @(negedge clk);
        check("tog_ready0b", {28'h0, req_ready}, 32'h0);
        cyc();
        ser_ready = 1'b1;
        wait_hs(16, "tog_hs");
        drain();

        // Masked requester is ignored; unmasking grants next cycle; mask drop mid-burst is harmless
        req_mask = 4'b1101;
        push(1, 8'h51, 1'b1);
        cyc();
        cyc();
        check("masked_grant", {28'h0, grant}, 32'h0);
        check("masked_busy", {31'h0, busy}, 32'h0);
        req_mask = 4'b1111;
        cyc();
        check("unmask_grant", {28'h0, grant}, 32'h2);
        req_mask = 4'b0000;
        wait_hs(17, "mask_drop_hs");
        drain();
        check("mask_drop_done", {31'h0, busy}, 32'h0);
        req_mask = 4'b1111;

        repeat (2) cyc();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
